// File: rtl/wallace_mul8_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wallace_mul8_seq_if
// Brief    : Operand/result handshakes plus shared 4x4 multiplier port bundle.
// Revision : 1.0
// ============================================================================
interface wallace_mul8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;

    // slave = the sequencing controller; master = requester, consumer and multiplier
    modport slave (
        input  in_valid, a, b, out_ready, mul_p,
        output in_ready, out_valid, prod, mul_a, mul_b
    );
    modport master (
        output in_valid, a, b, out_ready, mul_p,
        input  in_ready, out_valid, prod, mul_a, mul_b
    );
endinterface
`default_nettype wire

// File: rtl/wallace_mul8_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wallace_mul8_seq
// Brief    : 8x8 unsigned multiply sequenced over four 4x4 partial products.
// Revision : 1.0
// ============================================================================
module wallace_mul8_seq #(
    parameter int MUL_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    wallace_mul8_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic c_MUL_REG_EN = (MUL_REG != 0);

    state_t      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [15:0] prod_q;
    logic [1:0]  step_q;
    logic        phase_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [3:0]  mul_a_q;
    logic [3:0]  mul_b_q;

    logic [3:0]  shamt_w;
    logic [15:0] acc_d;
    logic [1:0]  step_d;
    logic [7:0]  next_ops_w;
    logic        sample_w;

    // Step k selects {A nibble, B nibble}: LL, LH, HL, HH
    function automatic logic [7:0] step_ops(input logic [1:0] k,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        case (k)
            2'd0:    step_ops = {a[3:0], b[3:0]};
            2'd1:    step_ops = {a[3:0], b[7:4]};
            2'd2:    step_ops = {a[7:4], b[3:0]};
            default: step_ops = {a[7:4], b[7:4]};
        endcase
    endfunction

    always_comb begin
        shamt_w = 4'd4;
        if (step_q == 2'd0) shamt_w = 4'd0;
        if (step_q == 2'd3) shamt_w = 4'd8;
        acc_d      = acc_q + ({8'h00, bus.mul_p} << shamt_w);
        step_d     = step_q + 2'd1;
        next_ops_w = step_ops(step_d, a_q, b_q);
        // With a registered multiplier the product is only valid in the second cycle
        sample_w   = !c_MUL_REG_EN || phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= 16'h0000;
            prod_q      <= 16'h0000;
            step_q      <= 2'd0;
            phase_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mul_a_q     <= 4'h0;
            mul_b_q     <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q                <= bus.a;
                        b_q                <= bus.b;
                        acc_q              <= 16'h0000;
                        step_q             <= 2'd0;
                        phase_q            <= 1'b0;
                        {mul_a_q, mul_b_q} <= step_ops(2'd0, bus.a, bus.b);
                        in_ready_q         <= 1'b0;
                        state_q            <= STEP;
                    end
                end
                STEP: begin
                    if (!sample_w) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        acc_q   <= acc_d;
                        if (step_q == 2'd3) begin
                            step_q      <= 2'd0;
                            prod_q      <= acc_d;
                            out_valid_q <= 1'b1;
                            mul_a_q     <= 4'h0;
                            mul_b_q     <= 4'h0;
                            state_q     <= DONE;
                        end else begin
                            step_q             <= step_d;
                            {mul_a_q, mul_b_q} <= next_ops_w;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.prod      = prod_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mul8_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wallace_mul8_seq
// Brief    : Vector table, corner sequences and random scoreboard for the multiplier.
// Revision : 1.0
// ============================================================================
module tb_wallace_mul8_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wallace_mul8_seq_if if0();
    wallace_mul8_seq_if if1();

    // Shared 4x4 multiplier: combinational for if0, output-registered for if1
    assign if0.mul_p = {4'h0, if0.mul_a} * {4'h0, if0.mul_b};
    always @(posedge clk) if1.mul_p <= {4'h0, if1.mul_a} * {4'h0, if1.mul_b};

    wallace_mul8_seq #(.MUL_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    wallace_mul8_seq #(.MUL_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept0(input logic [7:0] a, input logic [7:0] b);
        int n;
        if0.a = a;
        if0.b = b;
        if0.in_valid = 1'b1;
        n = 0;
        while (!if0.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", {31'b0, n < 50}, 32'd1);
        tick();
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_done0(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!if0.out_valid && lat < 50);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [7:0]  ops[4];
        logic [15:0] exp_q[$];
        logic [15:0] e;
        int          lat;
        int          seen_valid;
        int          n_ops;
        int          issued;
        int          received;
        int          cyc;
        logic        acc_now;
        logic        hs_now;

        vecs[0] = '{8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hFF, 16'h0000};
        vecs[3] = '{8'hA5, 8'h3C, 16'h26AC};
        vecs[4] = '{8'h01, 8'h01, 16'h0001};
        vecs[5] = '{8'h80, 8'h02, 16'h0100};
        vecs[6] = '{8'h0F, 8'hF0, 16'h0E10};
        vecs[7] = '{8'hF0, 8'h0F, 16'h0E10};
        ops[0] = 8'h24;
        ops[1] = 8'h23;
        ops[2] = 8'h14;
        ops[3] = 8'h13;

        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.a = 8'h00; if0.b = 8'h00; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = 8'h00; if1.b = 8'h00; if1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready0",  {31'b0, if0.in_ready},  32'd1);
        check("rst_out_valid0", {31'b0, if0.out_valid}, 32'd0);
        check("rst_prod0",      {16'b0, if0.prod},      32'h0);
        check("rst_mul0",       {24'b0, if0.mul_a, if0.mul_b}, 32'h0);
        check("rst_in_ready1",  {31'b0, if1.in_ready},  32'd1);
        check("rst_out_valid1", {31'b0, if1.out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Operand trace and latency for 0x12 * 0x34
        accept0(8'h12, 8'h34);
        for (int k = 0; k < 4; k++) begin
            check("trace_ops", {24'b0, if0.mul_a, if0.mul_b}, {24'b0, ops[k]});
            check("trace_no_valid", {31'b0, if0.out_valid}, 32'd0);
            tick();
        end
        check("trace_valid", {31'b0, if0.out_valid}, 32'd1);
        check("trace_prod",  {16'b0, if0.prod}, 32'h03A8);
        check("done_mul_zero", {24'b0, if0.mul_a, if0.mul_b}, 32'h0);

        // Backpressure: result held, new requests ignored
        for (int i = 0; i < 10; i++) begin
            if0.in_valid = 1'b1;
            if0.a = 8'h77;
            if0.b = 8'h11;
            check("bp_valid",    {31'b0, if0.out_valid}, 32'd1);
            check("bp_prod",     {16'b0, if0.prod}, 32'h03A8);
            check("bp_in_ready", {31'b0, if0.in_ready}, 32'd0);
            tick();
        end
        if0.out_ready = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b0;
        check("hs_valid_drop", {31'b0, if0.out_valid}, 32'd0);
        check("hs_in_ready",   {31'b0, if0.in_ready}, 32'd1);
        check("hs_prod_kept",  {16'b0, if0.prod}, 32'h03A8);
        tick();
        check("ignored_req_idle", {31'b0, if0.in_ready}, 32'd1);
        check("ignored_req_mul",  {24'b0, if0.mul_a, if0.mul_b}, 32'h0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            accept0(vecs[i].a, vecs[i].b);
            wait_done0(lat);
            check("vec_latency", lat, 32'd4);
            check("vec_prod", {16'b0, if0.prod}, {16'b0, vecs[i].p});
            if0.out_ready = 1'b1;
            tick();
            if0.out_ready = 1'b0;
            check("vec_valid_drop", {31'b0, if0.out_valid}, 32'd0);
        end

        // Asynchronous reset during step 2
        accept0(8'h55, 8'h77);
        tick();
        tick();
        check("mid_step2_ops", {24'b0, if0.mul_a, if0.mul_b}, 32'h57);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'b0, if0.in_ready},  32'd1);
        check("arst_out_valid", {31'b0, if0.out_valid}, 32'd0);
        check("arst_prod",      {16'b0, if0.prod},      32'h0);
        check("arst_mul",       {24'b0, if0.mul_a, if0.mul_b}, 32'h0);
        #2;
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if0.out_valid) seen_valid++;
        end
        check("arst_no_valid", seen_valid, 32'd0);
        accept0(8'hA5, 8'h3C);
        wait_done0(lat);
        check("post_rst_latency", lat, 32'd4);
        check("post_rst_prod", {16'b0, if0.prod}, 32'h26AC);
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;

        // Registered multiplier: each operand pair held two cycles
        if1.a = 8'h12;
        if1.b = 8'h34;
        if1.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) begin
                check("mr_ops", {24'b0, if1.mul_a, if1.mul_b}, {24'b0, ops[k]});
                check("mr_no_valid", {31'b0, if1.out_valid}, 32'd0);
                tick();
            end
        end
        check("mr_valid", {31'b0, if1.out_valid}, 32'd1);
        check("mr_prod",  {16'b0, if1.prod}, 32'h03A8);
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;
        check("mr_valid_drop", {31'b0, if1.out_valid}, 32'd0);

        // Random operands and consumer stalls against a product scoreboard
        n_ops = 1500;
        issued = 0;
        received = 0;
        cyc = 0;
        if0.in_valid = 1'b0;
        while (received < n_ops && cyc < 40000) begin
            hs_now  = if0.out_valid && if0.out_ready;
            acc_now = if0.in_valid && if0.in_ready;
            if (hs_now) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 32'd1, 32'd0);
                end else begin
                    check("rand_prod", {16'b0, if0.prod}, {16'b0, exp_q.pop_front()});
                end
                received++;
            end
            if (acc_now) begin
                e = if0.a * if0.b;
                exp_q.push_back(e);
                issued++;
            end
            tick();
            cyc++;
            if (acc_now) if0.in_valid = 1'b0;
            if (!if0.in_valid && issued < n_ops && $urandom_range(0, 3) != 0) begin
                if0.a = 8'($urandom);
                if0.b = 8'($urandom);
                if0.in_valid = 1'b1;
            end
            if0.out_ready = 1'($urandom_range(0, 1));
        end
        check("rand_count", received, n_ops);
        check("rand_issued", issued, n_ops);
        check("rand_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
